// File: rtl/mm_stream_tx.sv
// mm_stream_tx: loads A/B, streams them to the multiplier with the first byte one cycle after start, then collects the verdict and results.
// The byte stream has no backpressure. Define MMTX_TIMEOUT_EN to add a TO_CYC-cycle watchdog on the busy/result wait.
module mm_stream_tx #(
    parameter int MAX_DIM = 4,
    parameter int DW      = 8,
    parameter int OW      = 20,
    parameter int TO_CYC  = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic          cfg_sel,
    input  logic [3:0]    cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    input  logic [2:0]    a_rows,
    input  logic [2:0]    a_cols,
    input  logic [2:0]    b_rows,
    input  logic [2:0]    b_cols,
    input  logic          start,
    output logic [DW-1:0] mm_in_data,
    output logic          mm_col_end,
    output logic          mm_row_end,
    input  logic          mm_busy,
    input  logic          mm_valid,
    input  logic          mm_is_legal,
    input  logic          mm_change_row,
    input  logic [OW-1:0] mm_out_data,
    input  logic [3:0]    res_addr,
    output logic [OW-1:0] res_data,
    output logic [4:0]    res_count,
    output logic [2:0]    res_rows,
    output logic          legal,
    output logic          done,
    output logic          cfg_err,
    output logic          timeout
);
    localparam int         NB  = MAX_DIM * MAX_DIM;
    localparam logic [2:0] MD  = 3'(MAX_DIM);
    localparam logic [4:0] NB5 = 5'(NB);

    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_BUSY, VERDICT, COLLECT, FIN} state_t;
    state_t state;

    logic [DW-1:0] a_buf [NB];
    logic [DW-1:0] b_buf [NB];
    logic [OW-1:0] r_buf [NB];

    logic [2:0] ar, ac, br, bc, r, c;
    logic [3:0] lin;
    logic       dims_ok, accept, row_last, mat_last, capture, to_hit;
    logic [2:0] cur_rows, cur_cols, nxt_r, nxt_c;
    logic [3:0] nxt_lin;

    // Returns {row_end, col_end} for element (row, col) of a rows x cols matrix.
    function automatic logic [1:0] marks(input logic [2:0] row, input logic [2:0] col,
                                         input logic [2:0] rows, input logic [2:0] cols);
        logic ce;
        ce = (col == cols - 3'd1);
        return {ce && (row == rows - 3'd1), ce};
    endfunction

    always_comb begin
        dims_ok  = (a_rows != 3'd0) && (a_rows <= MD) && (a_cols != 3'd0) && (a_cols <= MD) &&
                   (b_rows != 3'd0) && (b_rows <= MD) && (b_cols != 3'd0) && (b_cols <= MD);
        accept   = (state == IDLE) && start && dims_ok;
        cur_rows = (state == SEND_B) ? br : ar;
        cur_cols = (state == SEND_B) ? bc : ac;
        row_last = (c == cur_cols - 3'd1);
        mat_last = row_last && (r == cur_rows - 3'd1);
        nxt_c    = row_last ? 3'd0 : c + 3'd1;
        nxt_r    = row_last ? r + 3'd1 : r;
        nxt_lin  = lin + 4'd1;
        capture  = (state == COLLECT) && mm_valid && mm_busy && (res_count < NB5);
        res_data = ({1'b0, res_addr} < NB5) ? r_buf[res_addr] : '0;
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && cfg_we && ({1'b0, cfg_addr} < NB5)) begin
            if (cfg_sel) b_buf[cfg_addr] <= cfg_wdata;
            else         a_buf[cfg_addr] <= cfg_wdata;
        end
        if (capture) r_buf[res_count[3:0]] <= mm_out_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ar         <= '0;
            ac         <= '0;
            br         <= '0;
            bc         <= '0;
            r          <= '0;
            c          <= '0;
            lin        <= '0;
            mm_in_data <= '0;
            mm_col_end <= 1'b0;
            mm_row_end <= 1'b0;
            res_count  <= '0;
            res_rows   <= '0;
            legal      <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ar        <= a_rows;
                        ac        <= a_cols;
                        br        <= b_rows;
                        bc        <= b_cols;
                        r         <= '0;
                        c         <= '0;
                        lin       <= '0;
                        res_count <= '0;
                        res_rows  <= '0;
                        legal     <= 1'b0;
                        mm_in_data <= a_buf[0];
                        {mm_row_end, mm_col_end} <= marks(3'd0, 3'd0, a_rows, a_cols);
                        state     <= SEND_A;
                    end else if (start) begin
                        cfg_err <= 1'b1;
                    end
                end
                SEND_A, SEND_B: begin
                    if (!mat_last) begin
                        r   <= nxt_r;
                        c   <= nxt_c;
                        lin <= nxt_lin;
                        mm_in_data <= (state == SEND_A) ? a_buf[nxt_lin] : b_buf[nxt_lin];
                        {mm_row_end, mm_col_end} <= marks(nxt_r, nxt_c, cur_rows, cur_cols);
                    end else if (state == SEND_A) begin
                        // B follows A's last element with no idle cycle.
                        r   <= '0;
                        c   <= '0;
                        lin <= '0;
                        mm_in_data <= b_buf[0];
                        {mm_row_end, mm_col_end} <= marks(3'd0, 3'd0, br, bc);
                        state <= SEND_B;
                    end else begin
                        mm_in_data <= '0;
                        mm_col_end <= 1'b0;
                        mm_row_end <= 1'b0;
                        state      <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (to_hit) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else if (mm_busy) begin
                        legal <= mm_is_legal;
                        state <= mm_is_legal ? COLLECT : VERDICT;
                    end
                end
                VERDICT: begin
                    if (to_hit || !mm_busy) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                COLLECT: begin
                    if (capture) res_count <= res_count + 5'd1;
                    if (mm_valid && mm_change_row) res_rows <= res_rows + 3'd1;
                    if (to_hit || !mm_busy) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MMTX_TIMEOUT_EN
    localparam int            TW     = $clog2(TO_CYC + 1);
    localparam logic [TW-1:0] TO_LIM = TW'(TO_CYC - 1);
    logic [TW-1:0] to_cnt;
    logic          waiting;

    assign waiting = (state == WAIT_BUSY) || (state == VERDICT) || (state == COLLECT);
    assign to_hit  = waiting && !mm_valid && (to_cnt == TO_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (!waiting || mm_valid) to_cnt <= '0;
            else                      to_cnt <= to_cnt + 1'b1;
            if (accept)      timeout <= 1'b0;
            else if (to_hit) timeout <= 1'b1;
        end
    end
`else
    // Watchdog compiled out; TO_CYC is referenced only to keep the parameter in use.
    assign to_hit  = 1'b0 & (TO_CYC > 0);
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_mm_stream_tx.sv
// Directed bench for mm_stream_tx: table of jobs plus hand sequences for cfg_err, mid-job reset and watchdog.
module tb_mm_stream_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0, cfg_sel = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [7:0]  cfg_wdata = '0;
    logic [2:0]  a_rows = '0, a_cols = '0, b_rows = '0, b_cols = '0;
    logic        start = 1'b0;
    logic [7:0]  mm_in_data;
    logic        mm_col_end, mm_row_end;
    logic        mm_busy = 1'b0, mm_valid = 1'b0, mm_is_legal = 1'b0, mm_change_row = 1'b0;
    logic [19:0] mm_out_data = '0;
    logic [3:0]  res_addr = '0;
    logic [19:0] res_data;
    logic [4:0]  res_count;
    logic [2:0]  res_rows;
    logic        legal, done, cfg_err, timeout;

    int n_tests = 0;
    int n_fail  = 0;

    mm_stream_tx dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
        .start(start), .mm_in_data(mm_in_data), .mm_col_end(mm_col_end), .mm_row_end(mm_row_end),
        .mm_busy(mm_busy), .mm_valid(mm_valid), .mm_is_legal(mm_is_legal),
        .mm_change_row(mm_change_row), .mm_out_data(mm_out_data), .res_addr(res_addr),
        .res_data(res_data), .res_count(res_count), .res_rows(res_rows), .legal(legal),
        .done(done), .cfg_err(cfg_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       ar, ac, br, bc;
        logic [15:0][7:0] a, b;
        logic             exp_legal;
        logic [4:0]       exp_cnt;
        logic [2:0]       exp_rows;
        logic [19:0]      exp_r0, exp_rlast;
        logic [1:0]       extra;
    } vec_t;

    vec_t tv [4];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_start(input vec_t v);
        int na, nb;
        na = int'(v.ar) * int'(v.ac);
        nb = int'(v.br) * int'(v.bc);
        for (int i = 0; i < na + nb; i++) begin
            cfg_we    = 1'b1;
            cfg_sel   = (i >= na);
            cfg_addr  = (i < na) ? 4'(i) : 4'(i - na);
            cfg_wdata = (i < na) ? v.a[i] : v.b[i - na];
            tick;
        end
        cfg_we = 1'b0;
        a_rows = v.ar; a_cols = v.ac; b_rows = v.br; b_cols = v.bc;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int na, nb, idx, rows, cols, rr, cc, s, nres;
        logic [7:0] ed;
        logic ec, er, is_leg;
        na = int'(v.ar) * int'(v.ac);
        nb = int'(v.br) * int'(v.bc);
        load_start(v);
        for (int i = 0; i < na + nb; i++) begin
            if (i < na) begin idx = i; rows = int'(v.ar); cols = int'(v.ac); ed = v.a[i]; end
            else begin idx = i - na; rows = int'(v.br); cols = int'(v.bc); ed = v.b[idx]; end
            rr = idx / cols;
            cc = idx % cols;
            ec = (cc == cols - 1);
            er = ec && (rr == rows - 1);
            check({tag, " byte"}, 32'({mm_in_data, mm_col_end, mm_row_end}), 32'({ed, ec, er}));
            // Writes and restarts while streaming must be ignored.
            cfg_we = (i == 0); cfg_sel = 1'b1; cfg_addr = 4'(nb - 1); cfg_wdata = 8'h55;
            start = (i == 1);
            tick;
        end
        cfg_we = 1'b0;
        start = 1'b0;
        check({tag, " quiet after stream"}, 32'({mm_in_data, mm_col_end, mm_row_end}), 32'd0);

        is_leg = (v.ac == v.br);
        mm_busy = 1'b1; mm_is_legal = is_leg; mm_valid = 1'b1; mm_out_data = 20'hABCDE;
        tick;
        mm_valid = 1'b0; mm_is_legal = 1'b0;
        if (is_leg) begin
            nres = int'(v.ar) * int'(v.bc);
            for (int i = 0; i < nres + int'(v.extra); i++) begin
                s = 0;
                cc = i % int'(v.bc);
                rr = i / int'(v.bc);
                if (i < nres)
                    for (int k = 0; k < int'(v.ac); k++)
                        s += int'($signed(v.a[rr * int'(v.ac) + k])) * int'($signed(v.b[k * int'(v.bc) + cc]));
                mm_valid = 1'b1; mm_out_data = 20'(s);
                mm_change_row = (i < nres) && (cc == int'(v.bc) - 1);
                tick;
                if (i % 2 == 1) begin mm_valid = 1'b0; mm_change_row = 1'b0; tick; end
            end
        end else begin
            mm_valid = 1'b1; mm_change_row = 1'b1; mm_out_data = 20'h12345;
            tick;
            mm_valid = 1'b0; mm_change_row = 1'b0;
            tick;
        end
        mm_valid = 1'b0; mm_change_row = 1'b0; mm_busy = 1'b0;
        tick;
        check({tag, " done pulse"}, 32'(done), 32'd1);
        tick;
        check({tag, " done cleared"}, 32'(done), 32'd0);
        check({tag, " legal"}, 32'(legal), 32'(v.exp_legal));
        check({tag, " res_count"}, 32'(res_count), 32'(v.exp_cnt));
        check({tag, " res_rows"}, 32'(res_rows), 32'(v.exp_rows));
        if (v.exp_cnt != 5'd0) begin
            res_addr = 4'd0; #1;
            check({tag, " res[0]"}, 32'(res_data), 32'(v.exp_r0));
            res_addr = 4'(v.exp_cnt - 5'd1); #1;
            check({tag, " res[last]"}, 32'(res_data), 32'(v.exp_rlast));
        end
    endtask

    initial begin
        tv[0] = '0;
        tv[0].ar = 3'd2; tv[0].ac = 3'd2; tv[0].br = 3'd2; tv[0].bc = 3'd2;
        tv[0].a[0] = 8'd1; tv[0].a[1] = 8'd2; tv[0].a[2] = 8'd3; tv[0].a[3] = 8'd4;
        tv[0].b[0] = 8'd5; tv[0].b[1] = 8'd6; tv[0].b[2] = 8'd7; tv[0].b[3] = 8'd8;
        tv[0].exp_legal = 1'b1; tv[0].exp_cnt = 5'd4; tv[0].exp_rows = 3'd2;
        tv[0].exp_r0 = 20'd19; tv[0].exp_rlast = 20'd50;

        tv[1] = '0;
        tv[1].ar = 3'd1; tv[1].ac = 3'd1; tv[1].br = 3'd1; tv[1].bc = 3'd1;
        tv[1].a[0] = 8'h80; tv[1].b[0] = 8'h80;
        tv[1].exp_legal = 1'b1; tv[1].exp_cnt = 5'd1; tv[1].exp_rows = 3'd1;
        tv[1].exp_r0 = 20'd16384; tv[1].exp_rlast = 20'd16384;

        tv[2] = '0;
        tv[2].ar = 3'd2; tv[2].ac = 3'd3; tv[2].br = 3'd2; tv[2].bc = 3'd2;
        for (int i = 0; i < 6; i++) tv[2].a[i] = 8'(i + 1);
        for (int i = 0; i < 4; i++) tv[2].b[i] = 8'(i + 1);

        tv[3] = '0;
        tv[3].ar = 3'd4; tv[3].ac = 3'd4; tv[3].br = 3'd4; tv[3].bc = 3'd4;
        for (int i = 0; i < 16; i++) begin tv[3].a[i] = 8'd127; tv[3].b[i] = 8'd127; end
        tv[3].exp_legal = 1'b1; tv[3].exp_cnt = 5'd16; tv[3].exp_rows = 3'd4;
        tv[3].exp_r0 = 20'd64516; tv[3].exp_rlast = 20'd64516; tv[3].extra = 2'd1;

        #2;
        check("reset outputs", 32'({mm_in_data, mm_col_end, mm_row_end, res_count, res_rows,
                                    legal, done, cfg_err, timeout}), 32'd0);
        #10 rst = 1'b0;
        tick;

        for (int j = 0; j < 4; j++) run_job(tv[j], $sformatf("job%0d", j));

        // Illegal dimensions: start rejected, previous results kept.
        for (int j = 0; j < 2; j++) begin
            a_rows = (j == 0) ? 3'd0 : 3'd2; a_cols = 3'd2; b_rows = 3'd2;
            b_cols = (j == 0) ? 3'd2 : 3'd5;
            start = 1'b1;
            tick;
            start = 1'b0;
            check("cfg_err pulse", 32'(cfg_err), 32'd1);
            check("cfg_err no stream", 32'({mm_in_data, mm_col_end, mm_row_end}), 32'd0);
            tick;
            check("cfg_err cleared", 32'({cfg_err, mm_col_end, mm_row_end}), 32'd0);
            check("cfg_err keeps res_count", 32'(res_count), 32'd16);
        end

        // Asynchronous reset in the middle of SEND_A.
        load_start(tv[0]);
        tick;
        check("pre-reset col_end", 32'({mm_in_data, mm_col_end}), 32'({8'd2, 1'b1}));
        #3 rst = 1'b1;
        #1 check("async reset clears stream", 32'({mm_in_data, mm_col_end, mm_row_end, done}), 32'd0);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("post-reset quiet", 32'({mm_in_data, mm_col_end, mm_row_end, done}), 32'd0);
        end
        run_job(tv[1], "post-reset job");

`ifdef MMTX_TIMEOUT_EN
        begin
            int cyc;
            load_start(tv[1]);
            tick;
            tick;
            cyc = 0;
            while (!done && cyc < 100) begin tick; cyc++; end
            check("watchdog cycles", 32'(cyc), 32'd64);
            check("timeout flag", 32'(timeout), 32'd1);
            tick;
            check("timeout sticky", 32'({timeout, done}), 32'({1'b1, 1'b0}));
        end
`else
        check("timeout tied low", 32'(timeout), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
